// File: rtl/lmg_pkg.sv
// Shared constants and types for the legal-move-generator move collector.
package lmg_pkg;

  localparam int unsigned NCOLS = 8;
  localparam int unsigned MOVEW = 12;

  // Board coordinate, 0..7 on each axis.
  typedef logic [2:0] coord_t;

  // Packed move, MSB first: {from_x, from_y, to_x, to_y}.
  typedef struct packed {
    coord_t from_x;
    coord_t from_y;
    coord_t to_x;
    coord_t to_y;
  } move_t;

  // Column identifiers; column A sits on the MSB of the column vectors.
  localparam logic [2:0] COLA = 3'o0;
  localparam logic [2:0] COLB = 3'o1;
  localparam logic [2:0] COLC = 3'o2;
  localparam logic [2:0] COLD = 3'o3;
  localparam logic [2:0] COLE = 3'o4;
  localparam logic [2:0] COLF = 3'o5;
  localparam logic [2:0] COLG = 3'o6;
  localparam logic [2:0] COLH = 3'o7;

  // Collector state encoding.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Bit position of a column inside the column vectors (A -> NCOLS-1).
  function automatic int unsigned col_to_bit(logic [2:0] col);
    return NCOLS - 1 - int'(col);
  endfunction

endpackage

// File: rtl/lmg_move_collector_if.sv
// Bundle between the LMG column units, the collector and the search stage.
interface lmg_move_collector_if #(
  parameter int unsigned NCOLS = 8,
  parameter int unsigned MOVEW = 12,
  parameter int unsigned CNTW  = 8
) ();

  logic                     newboard;
  logic [NCOLS-1:0]         col_move_valid;
  logic [NCOLS*MOVEW-1:0]   col_move;
  logic [NCOLS-1:0]         col_done;
  logic [NCOLS-1:0]         col_move_ack;
  logic                     move_valid;
  logic [MOVEW-1:0]         move_data;
  logic                     move_ready;
  logic [CNTW-1:0]          move_count;
  logic                     list_done;
  logic                     overflow;

  // Environment side: LMG columns plus the consuming search stage.
  modport master (
    output newboard, col_move_valid, col_move, col_done, move_ready,
    input  col_move_ack, move_valid, move_data, move_count, list_done, overflow
  );

  // Collector side.
  modport slave (
    input  newboard, col_move_valid, col_move, col_done, move_ready,
    output col_move_ack, move_valid, move_data, move_count, list_done, overflow
  );

endinterface

// File: rtl/lmg_move_fifo.sv
// First-word-fall-through move FIFO with synchronous flush.
module lmg_move_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  // Drive zero while empty so the output never shows stale storage.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset since data_o is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/lmg_move_collector.sv
// Collects moves from the LMG column units, arbitrates round-robin, buffers
// them and streams them to the search stage while counting the move list.
module lmg_move_collector #(
  parameter int unsigned NCOLS = 8,
  parameter int unsigned MOVEW = 12,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  lmg_move_collector_if.slave  bus
);

  import lmg_pkg::*;

  localparam int unsigned PTRW = $clog2(NCOLS);
  localparam logic [PTRW-1:0] PtrReset = PTRW'(col_to_bit(COLA));

  logic [1:0]          state_q, state_d;
  logic [PTRW-1:0]     ptr_q, ptr_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic                found;
  logic [PTRW-1:0]     grant_idx;
  logic [NCOLS-1:0]    ack;
  int unsigned         idx;

  logic                fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [MOVEW-1:0]    fifo_rdata;
  logic [MOVEW-1:0]    push_data;
  logic                pop;

  // Round-robin search downward from the pointer (A towards H, wrapping).
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr_q;
    idx       = 0;
    if (state_q == COLLECT && !bus.newboard && !fifo_full) begin
      for (int unsigned k = 0; k < NCOLS; k++) begin
        idx = (int'(ptr_q) + NCOLS - k) % NCOLS;
        if (!found && bus.col_move_valid[idx]) begin
          found     = 1'b1;
          grant_idx = idx[PTRW-1:0];
        end
      end
    end
    ack = found ? (NCOLS'(1) << grant_idx) : '0;
  end

  assign push_data        = bus.col_move[int'(grant_idx)*MOVEW +: MOVEW];
  assign pop              = !fifo_empty && bus.move_ready;
  assign bus.col_move_ack = ack;
  assign bus.move_valid   = !fifo_empty;
  assign bus.move_data    = fifo_rdata;
  assign bus.move_count   = cnt_q;
  assign bus.list_done    = done_q;
  assign bus.overflow     = ovf_q;

  // FSM, pointer, counter and flag next-state; newboard overrides everything.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    if (bus.newboard) begin
      state_d = COLLECT;
      ptr_d   = PtrReset;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        COLLECT: begin
          if (found) begin
            ptr_d = (grant_idx == '0) ? PTRW'(NCOLS - 1) : grant_idx - 1'b1;
            if (cnt_q == {CNTW{1'b1}}) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if ((&bus.col_done) && !(|bus.col_move_valid) && (fifo_level == '0) && !found) begin
            state_d = DONE;
          end
        end
        DONE: begin
          // Flag lags state entry by one cycle.
          done_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PtrReset;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  lmg_move_fifo #(
    .WIDTH (MOVEW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.newboard),
    .push_i  (found),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_lmg_move_collector.sv
// Directed bench for the LMG move collector.
module tb_lmg_move_collector;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  lmg_move_collector_if bus ();

  lmg_move_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_newboard();
    bus.newboard = 1'b1;
    tick();
    bus.newboard = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.newboard = 1'b0;
    bus.col_move_valid = 8'hFF;
    bus.col_move = '0;
    bus.col_done = '0;
    bus.move_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.move_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_move_valid: got %0b want 0", bus.move_valid); end
    n_cmp++; if (bus.move_data !== 12'h000) begin n_bad++;
      $display("FAIL reset_move_data: got %0h want 0", bus.move_data); end
    n_cmp++; if (bus.move_count !== 8'd0) begin n_bad++;
      $display("FAIL reset_move_count: got %0d want 0", bus.move_count); end
    n_cmp++; if (bus.list_done !== 1'b0) begin n_bad++;
      $display("FAIL reset_list_done: got %0b want 0", bus.list_done); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++;
      $display("FAIL reset_overflow: got %0b want 0", bus.overflow); end
    n_cmp++; if (bus.col_move_ack !== 8'h00) begin n_bad++;
      $display("FAIL idle_ack: got %0h want 0", bus.col_move_ack); end
    bus.col_move_valid = 8'h00;
  endtask

  task automatic test_single();
    bus.col_move[5*12 +: 12] = 12'o2324;
    bus.col_move_valid = 8'h20;
    bus.move_ready = 1'b1;
    bus.newboard = 1'b1;
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h00) begin n_bad++;
      $display("FAIL single_nb_ack: got %0h want 0", bus.col_move_ack); end
    tick();
    bus.newboard = 1'b0;
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h20) begin n_bad++;
      $display("FAIL single_ack: got %0h want 20", bus.col_move_ack); end
    tick();
    bus.col_move_valid = 8'h00;
    n_cmp++; if (bus.move_valid !== 1'b1) begin n_bad++;
      $display("FAIL single_valid: got %0b want 1", bus.move_valid); end
    n_cmp++; if (bus.move_data !== 12'o2324) begin n_bad++;
      $display("FAIL single_data: got %0o want 2324", bus.move_data); end
    n_cmp++; if (bus.move_count !== 8'd1) begin n_bad++;
      $display("FAIL single_count: got %0d want 1", bus.move_count); end
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h00) begin n_bad++;
      $display("FAIL single_ack_once: got %0h want 0", bus.col_move_ack); end
    tick();
    n_cmp++; if (bus.move_valid !== 1'b0) begin n_bad++;
      $display("FAIL single_popped: got %0b want 0", bus.move_valid); end
    bus.col_done = 8'hFF;
    tick();
    n_cmp++; if (bus.list_done !== 1'b0) begin n_bad++;
      $display("FAIL single_done_early: got %0b want 0", bus.list_done); end
    tick();
    n_cmp++; if (bus.list_done !== 1'b1) begin n_bad++;
      $display("FAIL single_done: got %0b want 1", bus.list_done); end
    n_cmp++; if (bus.move_count !== 8'd1) begin n_bad++;
      $display("FAIL single_final_count: got %0d want 1", bus.move_count); end
    bus.col_done = 8'h00;
  endtask

  task automatic test_round_robin();
    int unsigned b;
    for (int i = 0; i < 8; i++) bus.col_move[i*12 +: 12] = 12'h100 + 12'(i);
    bus.col_move_valid = 8'hFF;
    bus.move_ready = 1'b1;
    pulse_newboard();
    for (int k = 0; k < 16; k++) begin
      b = 7 - (k % 8);
      #1;
      n_cmp++; if (bus.col_move_ack !== (8'h01 << b)) begin n_bad++;
        $display("FAIL rr_ack[%0d]: got %0h want %0h", k, bus.col_move_ack, 8'h01 << b); end
      tick();
      n_cmp++; if (bus.move_data !== 12'h100 + 12'(b)) begin n_bad++;
        $display("FAIL rr_data[%0d]: got %0h want %0h", k, bus.move_data, 12'h100 + 12'(b)); end
    end
    n_cmp++; if (bus.move_count !== 8'd16) begin n_bad++;
      $display("FAIL rr_count: got %0d want 16", bus.move_count); end
    bus.col_move_valid = 8'h00;
    tick();
  endtask

  task automatic test_full_stall();
    bus.move_ready = 1'b0;
    bus.col_move_valid = 8'hC0;
    pulse_newboard();
    repeat (16) tick();
    n_cmp++; if (bus.move_count !== 8'd16) begin n_bad++;
      $display("FAIL full_count: got %0d want 16", bus.move_count); end
    n_cmp++; if (bus.move_data !== 12'h107) begin n_bad++;
      $display("FAIL full_data: got %0h want 107", bus.move_data); end
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h00) begin n_bad++;
      $display("FAIL full_ack: got %0h want 0", bus.col_move_ack); end
    tick();
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h00 || bus.move_data !== 12'h107) begin n_bad++;
      $display("FAIL full_hold: got ack %0h data %0h want ack 0 data 107",
               bus.col_move_ack, bus.move_data); end
    bus.move_ready = 1'b1;
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h00) begin n_bad++;
      $display("FAIL full_pop_cycle_ack: got %0h want 0", bus.col_move_ack); end
    tick();
    bus.move_ready = 1'b0;
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h80) begin n_bad++;
      $display("FAIL full_resume_ack: got %0h want 80", bus.col_move_ack); end
    n_cmp++; if (bus.move_data !== 12'h106) begin n_bad++;
      $display("FAIL full_next_data: got %0h want 106", bus.move_data); end
    tick();
    n_cmp++; if (bus.move_count !== 8'd17) begin n_bad++;
      $display("FAIL full_count17: got %0d want 17", bus.move_count); end
    bus.col_move_valid = 8'h00;
  endtask

  task automatic test_newboard_flush();
    bus.move_ready = 1'b0;
    bus.col_move_valid = 8'h80;
    pulse_newboard();
    repeat (7) tick();
    bus.col_move_valid = 8'h00;
    bus.move_ready = 1'b1;
    tick();
    tick();
    bus.move_ready = 1'b0;
    n_cmp++; if (bus.move_count !== 8'd7 || bus.move_valid !== 1'b1) begin n_bad++;
      $display("FAIL flush_setup: got count %0d valid %0b want 7 1",
               bus.move_count, bus.move_valid); end
    bus.newboard = 1'b1;
    bus.col_move_valid = 8'h80;
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h00) begin n_bad++;
      $display("FAIL flush_nb_ack: got %0h want 0", bus.col_move_ack); end
    tick();
    bus.newboard = 1'b0;
    bus.col_move_valid = 8'h00;
    n_cmp++; if (bus.move_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_valid: got %0b want 0", bus.move_valid); end
    n_cmp++; if (bus.move_count !== 8'd0) begin n_bad++;
      $display("FAIL flush_count: got %0d want 0", bus.move_count); end
    n_cmp++; if (bus.list_done !== 1'b0) begin n_bad++;
      $display("FAIL flush_list_done: got %0b want 0", bus.list_done); end
    bus.col_move_valid = 8'h80;
    #1;
    n_cmp++; if (bus.col_move_ack !== 8'h80) begin n_bad++;
      $display("FAIL flush_collect_ack: got %0h want 80", bus.col_move_ack); end
    bus.col_move_valid = 8'h00;
    tick();
    bus.move_ready = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    bus.move_ready = 1'b1;
    bus.col_move_valid = 8'hFF;
    pulse_newboard();
    repeat (300) tick();
    n_cmp++; if (bus.move_count !== 8'd255) begin n_bad++;
      $display("FAIL ovf_count: got %0d want 255", bus.move_count); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++;
      $display("FAIL ovf_flag: got %0b want 1", bus.overflow); end
    bus.col_move_valid = 8'h00;
    pulse_newboard();
    n_cmp++; if (bus.move_count !== 8'd0 || bus.overflow !== 1'b0) begin n_bad++;
      $display("FAIL ovf_clear: got count %0d ovf %0b want 0 0",
               bus.move_count, bus.overflow); end
  endtask

  task automatic test_done_at_newboard();
    bus.move_ready = 1'b0;
    bus.col_move_valid = 8'h00;
    bus.col_done = 8'hFF;
    pulse_newboard();
    n_cmp++; if (bus.list_done !== 1'b0 || bus.move_valid !== 1'b0) begin n_bad++;
      $display("FAIL dnb_edge1: got done %0b valid %0b want 0 0", bus.list_done, bus.move_valid); end
    tick();
    n_cmp++; if (bus.list_done !== 1'b0 || bus.move_valid !== 1'b0) begin n_bad++;
      $display("FAIL dnb_edge2: got done %0b valid %0b want 0 0", bus.list_done, bus.move_valid); end
    tick();
    n_cmp++; if (bus.list_done !== 1'b1) begin n_bad++;
      $display("FAIL dnb_done: got %0b want 1", bus.list_done); end
    n_cmp++; if (bus.move_count !== 8'd0 || bus.move_valid !== 1'b0) begin n_bad++;
      $display("FAIL dnb_count: got count %0d valid %0b want 0 0", bus.move_count, bus.move_valid); end
    bus.col_done = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_newboard_flush();
    test_overflow();
    test_done_at_newboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
